expression_pipe_eval: RTL and testbench

//  Parametrised, pipelined successor to the fixed combinational expression blocks. Evaluates

---
 rtl/expression_pipe_eval.sv | 176 +++++++++++++++++
 tb/tb_expression_pipe_eval.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/expression_pipe_eval.sv
// expression_pipe_eval
//   Two-stage pipelined expression evaluator over LANES parallel lanes.
//   Operand a is unsigned and b is signed. Both are extended to RW = 2*W bits
//   and evaluated with the per-lane 3-bit opcode. Opcode 7 accumulates A*B
//   into a per-lane saturating accumulator.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input beat handshake
//   in_a, in_b, in_op     per-lane operands and opcode (lane i at [i*W +: W], [i*3 +: 3])
//   acc_clr               synchronous clear of every lane accumulator
//   out_valid / out_ready result beat handshake
//   out_y                 per-lane result, lane i at [i*RW +: RW]
//   out_sat               per-lane saturation flag (ACC only)
//
// Handshake: a beat moves across a port on the rising edge where valid and
//   ready are both high. Stage 1 advances into stage 2 whenever stage 2 is
//   empty or is being drained (s1_adv = !out_valid | out_ready). The input is
//   ready when stage 1 is empty or advancing. in_ready never depends on
//   in_valid. Stage-2 outputs are held while out_valid & !out_ready.
module expression_pipe_eval #(
  parameter int W     = 6,
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic [LANES*3-1:0]   in_op,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*2*W-1:0] out_y,
  output logic [LANES-1:0]     out_sat
);
  localparam int RW = 2 * W;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_ASR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;
  localparam logic [2:0] OP_RED = 3'd6;
  localparam logic [2:0] OP_ACC = 3'd7;

  localparam logic [RW-1:0] SAT_MAX = {1'b0, {(RW-1){1'b1}}};
  localparam logic [RW-1:0] SAT_MIN = {1'b1, {(RW-1){1'b0}}};

  logic               r_s1_valid;
  logic               r_s2_valid;
  logic [LANES*W-1:0] r_s1_a;
  logic [LANES*W-1:0] r_s1_b;
  logic [LANES*3-1:0] r_s1_op;

  logic w_s1_adv;
  logic w_s2_load;

  assign w_s1_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_s2_load = r_s1_valid && w_s1_adv;
  assign out_valid = r_s2_valid;

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
        r_s1_op <= in_op;
      end
    end
  end

  // Stage 2: shared valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic [2:0]    w_op;
    logic [RW-1:0] w_a_ext;
    logic [RW-1:0] w_b_ext;
    logic [RW-1:0] w_prod;
    logic [RW-1:0] w_alu;
    logic [RW-1:0] w_acc_base;
    logic [RW:0]   w_acc_sum;
    logic [RW-1:0] w_acc_new;
    logic [RW-1:0] w_y;
    logic [31:0]   w_a_amt;
    logic [31:0]   w_b_amt;
    logic          w_acc_ovf;
    logic          w_is_acc;
    logic          w_acc_upd;
    logic [RW-1:0] r_acc;
    logic [RW-1:0] r_y;
    logic          r_sat;

    assign w_a     = r_s1_a[i*W +: W];
    assign w_b     = r_s1_b[i*W +: W];
    assign w_op    = r_s1_op[i*3 +: 3];
    assign w_a_ext = {{(RW-W){1'b0}}, w_a};
    assign w_b_ext = {{(RW-W){w_b[W-1]}}, w_b};
    // Product of a W-bit unsigned and W-bit signed value always fits in RW bits.
    assign w_prod  = $signed(w_a_ext) * $signed(w_b_ext);
    assign w_a_amt = 32'(w_a);
    assign w_b_amt = 32'(w_b);

    always_comb begin
      w_alu = '0;
      case (w_op)
        OP_ADD: w_alu = w_a_ext + w_b_ext;
        OP_SUB: w_alu = w_a_ext - w_b_ext;
        OP_MUL: w_alu = w_prod;
        OP_ASR: begin
          // if/else rather than ?: so the shift keeps its signed context
          if (w_a_amt >= RW) w_alu = {RW{w_b[W-1]}};
          else               w_alu = $signed(w_b_ext) >>> w_a;
        end
        OP_SHL: begin
          if (w_b_amt >= RW) w_alu = '0;
          else               w_alu = w_a_ext << w_b;
        end
        OP_CMP: w_alu = {{(RW-3){1'b0}},
                         $signed(w_a_ext) <  $signed(w_b_ext),
                         $signed(w_a_ext) == $signed(w_b_ext),
                         $signed(w_a_ext) >  $signed(w_b_ext)};
        OP_RED: w_alu = {{(RW-4){1'b0}}, ~^w_a, ^w_b, &w_a, |w_b};
        default: w_alu = '0;
      endcase
    end

    // A clear in the same cycle as the ACC move restarts the sum from zero.
    assign w_acc_base = acc_clr ? '0 : r_acc;
    assign w_acc_sum  = {w_acc_base[RW-1], w_acc_base} + {w_prod[RW-1], w_prod};
    assign w_acc_ovf  = w_acc_sum[RW] ^ w_acc_sum[RW-1];
    assign w_acc_new  = !w_acc_ovf ? w_acc_sum[RW-1:0] :
                        (w_acc_sum[RW] ? SAT_MIN : SAT_MAX);
    assign w_is_acc   = (w_op == OP_ACC);
    assign w_acc_upd  = w_s2_load && w_is_acc;
    assign w_y        = w_is_acc ? w_acc_new : w_alu;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_y   <= '0;
        r_sat <= 1'b0;
        r_acc <= '0;
      end else begin
        if (w_s2_load) begin
          r_y   <= w_y;
          r_sat <= w_is_acc && w_acc_ovf;
        end
        if (w_acc_upd)    r_acc <= w_acc_new;
        else if (acc_clr) r_acc <= '0;
      end
    end

    assign out_y[i*RW +: RW] = r_y;
    assign out_sat[i]        = r_sat;
  end

endmodule

// File: tb/tb_expression_pipe_eval.sv
// Directed and randomised bench for expression_pipe_eval (W=6, LANES=2, RW=12).
module tb_expression_pipe_eval;
  localparam int NB = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic [5:0]  in_op;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_y;
  logic [1:0]  out_sat;

  int n_cmp = 0;
  int n_err = 0;

  logic [25:0] exp_q[$];
  int          acc_m[2];

  expression_pipe_eval #(.W(6), .LANES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sat   (out_sat)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One beat through an empty pipe. Lane 1 always carries ADD 1+1 = 0x002.
  // Called and returns at posedge+1.
  task automatic beat(input string tag, input logic [2:0] op, input logic [5:0] a,
                      input logic [5:0] b, input bit clr, input logic [11:0] exp_y,
                      input logic exp_sat);
    in_valid  = 1'b1;
    in_op     = {3'd0, op};
    in_a      = {6'd1, a};
    in_b      = {6'd1, b};
    out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_clr  = clr;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    acc_clr = 1'b0;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_y"}, 32'(out_y), {8'h00, 12'h002, exp_y});
    chk({tag, "_sat"}, 32'(out_sat), {30'd0, 1'b0, exp_sat});
    @(posedge clk); #1;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  // Integer reference for one lane; updates the model accumulator on ACC.
  task automatic model_lane(input int ln, input logic [5:0] a, input logic [5:0] b,
                            input logic [2:0] op, output logic [11:0] y, output logic s);
    int av, bv, r;
    av = int'(a);
    bv = (b >= 6'd32) ? int'(b) - 64 : int'(b);
    s  = 1'b0;
    r  = 0;
    case (op)
      3'd0: r = av + bv;
      3'd1: r = av - bv;
      3'd2: r = av * bv;
      3'd3: r = (av >= 12) ? ((bv < 0) ? -1 : 0) : (bv >>> av);
      3'd4: r = (av < 0) ? 0 : ((int'(b) >= 12) ? 0 : (av << int'(b)));
      3'd5: r = ((av < bv) ? 4 : 0) + ((av == bv) ? 2 : 0) + ((av > bv) ? 1 : 0);
      3'd6: r = (($countones(a) % 2 == 0) ? 8 : 0) + (($countones(b) % 2 == 1) ? 4 : 0)
              + ((a == 6'h3F) ? 2 : 0) + ((b != 6'd0) ? 1 : 0);
      default: begin
        r = acc_m[ln] + av * bv;
        if (r > 2047) begin
          r = 2047;
          s = 1'b1;
        end else if (r < -2048) begin
          r = -2048;
          s = 1'b1;
        end
        acc_m[ln] = r;
      end
    endcase
    y = r[11:0];
  endtask

  task automatic push_expected();
    logic [11:0] y0, y1;
    logic        s0, s1;
    model_lane(0, in_a[5:0],  in_b[5:0],  in_op[2:0], y0, s0);
    model_lane(1, in_a[11:6], in_b[11:6], in_op[5:3], y1, s1);
    exp_q.push_back({s1, s0, y1, y0});
  endtask

  logic [23:0] s_exp[6] = '{24'hFFF00A, 24'h00000C, 24'h00100E,
                            24'h002010, 24'h003012, 24'h004014};

  initial begin
    int          sent, got, n_out;
    bit          prev_stall, fired;
    logic [23:0] prev_y;
    logic [1:0]  prev_sat;
    logic [25:0] e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_y",     32'(out_y),     32'd0);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // arithmetic, shifts, compare, reduce
    beat("add",      3'd0, 6'd63, 6'h20, 1'b0, 12'h01F, 1'b0);
    beat("sub",      3'd1, 6'd0,  6'h20, 1'b0, 12'h020, 1'b0);
    beat("mul",      3'd2, 6'd63, 6'h20, 1'b0, 12'h820, 1'b0);
    beat("asr3",     3'd3, 6'd3,  6'h20, 1'b0, 12'hFFC, 1'b0);
    beat("asr40",    3'd3, 6'd40, 6'h20, 1'b0, 12'hFFF, 1'b0);
    beat("asr12pos", 3'd3, 6'd12, 6'h1F, 1'b0, 12'h000, 1'b0);
    beat("shl5",     3'd4, 6'd63, 6'd5,  1'b0, 12'h7E0, 1'b0);
    beat("shlneg",   3'd4, 6'd63, 6'h3F, 1'b0, 12'h000, 1'b0);
    beat("shl11",    3'd4, 6'd1,  6'd11, 1'b0, 12'h800, 1'b0);
    beat("shl12",    3'd4, 6'd1,  6'd12, 1'b0, 12'h000, 1'b0);
    beat("cmp_gt",   3'd5, 6'd63, 6'h3F, 1'b0, 12'h001, 1'b0);
    beat("cmp_eq",   3'd5, 6'd0,  6'd0,  1'b0, 12'h002, 1'b0);
    beat("cmp_lt",   3'd5, 6'd1,  6'd5,  1'b0, 12'h004, 1'b0);
    beat("red0",     3'd6, 6'd0,  6'd0,  1'b0, 12'h008, 1'b0);
    beat("red_all",  3'd6, 6'd63, 6'd1,  1'b0, 12'h00F, 1'b0);

    // accumulator and saturation
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    beat("acc1",     3'd7, 6'd63, 6'h20, 1'b0, 12'h820, 1'b0);
    beat("acc2sat",  3'd7, 6'd63, 6'h20, 1'b0, 12'h800, 1'b1);
    beat("acc_clr",  3'd7, 6'd1,  6'd5,  1'b1, 12'h005, 1'b0);

    // stream of 6 beats with a downstream stall
    sent       = 0;
    got        = 0;
    prev_stall = 1'b0;
    prev_y     = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = !(c >= 2 && c <= 6);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        in_a  = {6'(sent), 6'(10 + sent)};
        in_b  = {6'd1, 6'(sent)};
        in_op = {3'd1, 3'd0};
      end
      #1;
      if (c < 3) chk($sformatf("strm_rdy%0d", c), 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
      if (prev_stall) chk("strm_hold", 32'(out_y), 32'(prev_y));
      if (out_valid && out_ready) begin
        chk($sformatf("strm_y%0d", got), 32'(out_y), 32'(s_exp[got]));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("strm_cnt", 32'(got), 32'd6);

    // asynchronous reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 6'd0;
    in_a      = {6'd2, 6'd3};
    in_b      = {6'd4, 6'd5};
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flt_full_vld", 32'(out_valid), 32'd1);
    chk("flt_full_rdy", 32'(in_ready),  32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("flt_rst_vld", 32'(out_valid), 32'd0);
    chk("flt_rst_rdy", 32'(in_ready),  32'd1);
    chk("flt_rst_y",   32'(out_y),     32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("flt_discard0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("flt_discard1", 32'(out_valid), 32'd0);
    beat("rst_acc", 3'd7, 6'd1, 6'd1, 1'b0, 12'h001, 1'b0);

    // random traffic against the integer reference
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr    = 1'b0;
    acc_m[0]   = 0;
    acc_m[1]   = 0;
    sent       = 0;
    n_out      = 0;
    prev_stall = 1'b0;
    prev_y     = '0;
    prev_sat   = '0;
    for (int c = 0; c < 60000 && n_out < NB; c++) begin
      if (!in_valid && sent < NB && $urandom_range(3, 0) != 0) begin
        in_valid = 1'b1;
        in_a     = 12'($urandom_range(4095, 0));
        in_b     = 12'($urandom_range(4095, 0));
        in_op    = 6'($urandom_range(63, 0));
      end
      out_ready = ($urandom_range(3, 0) != 0);
      #1;
      if (prev_stall) begin
        chk("rnd_hold_y",   32'(out_y),   32'(prev_y));
        chk("rnd_hold_sat", 32'(out_sat), 32'(prev_sat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_y",   32'(out_y),   32'(e[23:0]));
          chk("rnd_sat", 32'(out_sat), 32'(e[25:24]));
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      prev_sat   = out_sat;
      fired      = in_valid && in_ready;
      if (fired) begin
        push_expected();
        sent++;
      end
      @(posedge clk); #1;
      if (fired) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("rnd_count",   32'(n_out),        32'(NB));
    chk("rnd_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
